// File: rtl/video_regfile_pkg.sv
// Shared register indices, VRAM access states and address-increment constants
// for the PPU register decoder and register file.
package video_regdec_signals;

  localparam int R_ctrl    = 0;
  localparam int R_mask    = 1;
  localparam int R_status  = 2;
  localparam int R_oamaddr = 3;
  localparam int R_oamdata = 4;
  localparam int R_scroll  = 5;
  localparam int R_addr    = 6;
  localparam int R_data    = 7;

  localparam int C_inc_1  = 1;
  localparam int C_inc_32 = 32;

  typedef enum logic [1:0] {
    S_idle = 2'd0,
    S_rd   = 2'd1,
    S_wr   = 2'd2
  } vram_state_e;

  function automatic logic [7:0] status_byte(input logic       vblank,
                                             input logic       spr0,
                                             input logic       ovf,
                                             input logic [7:0] open_bus);
    return {vblank, spr0, ovf, open_bus[4:0]};
  endfunction

endpackage

// File: rtl/video_scroll_latch.sv
// Scroll/address latches: temporary address t, current address v, fine X and
// the shared first/second write toggle w, plus the post-access increment of v.
module video_scroll_latch
  import video_regdec_signals::*;
#(
  parameter int P_inc_wrap = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_ctrl_i,
  input  logic                  wr_scroll_i,
  input  logic                  wr_addr_i,
  input  logic                  status_rd_i,
  input  logic                  inc_i,
  input  logic                  inc_32_i,
  input  logic [7:0]            data_i,
  output logic [P_inc_wrap-1:0] t_o,
  output logic [P_inc_wrap-1:0] v_o,
  output logic [2:0]            fine_x_o
);

  localparam logic [P_inc_wrap-1:0] L_inc_1  = P_inc_wrap'(C_inc_1);
  localparam logic [P_inc_wrap-1:0] L_inc_32 = P_inc_wrap'(C_inc_32);

  logic [P_inc_wrap-1:0] t_q, t_d;
  logic [P_inc_wrap-1:0] v_q, v_d;
  logic [2:0]            fine_x_q, fine_x_d;
  logic                  w_q, w_d;

  always_comb begin
    t_d      = t_q;
    v_d      = v_q;
    fine_x_d = fine_x_q;
    w_d      = w_q;

    if (wr_ctrl_i) begin
      t_d[11:10] = data_i[1:0];
    end

    if (wr_scroll_i) begin
      if (!w_q) begin
        t_d[4:0] = data_i[7:3];
        fine_x_d = data_i[2:0];
        w_d      = 1'b1;
      end else begin
        t_d[14:12] = data_i[2:0];
        t_d[9:5]   = data_i[7:3];
        w_d        = 1'b0;
      end
    end

    // Second address write copies the freshly completed t into v.
    if (wr_addr_i) begin
      if (!w_q) begin
        t_d[13:8] = data_i[5:0];
        t_d[14]   = 1'b0;
        w_d       = 1'b1;
      end else begin
        t_d[7:0] = data_i;
        v_d      = t_d;
        w_d      = 1'b0;
      end
    end

    if (inc_i) begin
      v_d = v_q + (inc_32_i ? L_inc_32 : L_inc_1);
    end

    if (status_rd_i) begin
      w_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t_q      <= '0;
      v_q      <= '0;
      fine_x_q <= '0;
      w_q      <= 1'b0;
    end else begin
      t_q      <= t_d;
      v_q      <= v_d;
      fine_x_q <= fine_x_d;
      w_q      <= w_d;
    end
  end

  assign t_o      = t_q;
  assign v_o      = v_q;
  assign fine_x_o = fine_x_q;

endmodule

// File: rtl/video_regfile.sv
// PPU-side register file: control/mask/OAM address, status flags, PPUDATA
// read buffer and the VRAM access sequencer behind $2007.
//
// state  | meaning
// S_idle | no VRAM access outstanding; $2007 accesses are accepted
// S_rd   | read request held until ack, ack data loads the read buffer
// S_wr   | write request held until ack
module video_regfile
  import video_regdec_signals::*;
#(
  parameter int P_inc_wrap = 15
) (
  input  logic                  I_clock,
  input  logic                  I_reset,
  input  logic [7:0]            I_reg_wrfall,
  input  logic [7:0]            I_reg_rdrise,
  input  logic [7:0]            I_reg_rdfall,
  input  logic [7:0]            I_data,
  output logic [7:0]            O_data,
  input  logic                  I_vblank_set,
  input  logic                  I_vblank_clear,
  input  logic                  I_spr0_hit,
  input  logic                  I_spr_ovf,
  output logic [7:0]            O_ctrl,
  output logic [7:0]            O_mask,
  output logic [7:0]            O_oam_addr,
  output logic                  O_oam_wren,
  output logic [7:0]            O_oam_wdata,
  input  logic [7:0]            I_oam_rdata,
  output logic [P_inc_wrap-1:0] O_v,
  output logic [P_inc_wrap-1:0] O_t,
  output logic [2:0]            O_fine_x,
  output logic                  O_vram_req,
  output logic                  O_vram_we,
  output logic [13:0]           O_vram_addr,
  output logic [7:0]            O_vram_wdata,
  input  logic                  I_vram_ack,
  input  logic [7:0]            I_vram_rdata,
  output logic                  O_nmi
);

  vram_state_e state_q, state_d;

  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic        oam_wren_q, oam_wren_d;
  logic [7:0]  oam_wdata_q, oam_wdata_d;
  logic [7:0]  open_bus_q, open_bus_d;
  logic        vblank_q, vblank_d;
  logic [7:0]  buf_q, buf_d;
  logic [7:0]  data_q, data_d;
  logic [13:0] vram_addr_q, vram_addr_d;
  logic [7:0]  vram_wdata_q, vram_wdata_d;

  logic                  idle;
  logic                  data_wr;
  logic                  data_rd;
  logic                  vram_go;
  logic [P_inc_wrap-1:0] v_cur;
  logic                  unused_rdfall;

  assign idle    = (state_q == S_idle);
  assign data_wr = I_reg_wrfall[R_data];
  assign data_rd = I_reg_rdfall[R_data];
  // $2007 accesses arriving while a transfer is in flight are dropped entirely.
  assign vram_go = (data_wr | data_rd) & idle;

  assign unused_rdfall = ^{I_reg_rdfall[6:3], I_reg_rdfall[1:0]};

  video_scroll_latch #(
    .P_inc_wrap(P_inc_wrap)
  ) u_scroll (
    .clk_i      (I_clock),
    .rst_i      (I_reset),
    .wr_ctrl_i  (I_reg_wrfall[R_ctrl]),
    .wr_scroll_i(I_reg_wrfall[R_scroll]),
    .wr_addr_i  (I_reg_wrfall[R_addr]),
    .status_rd_i(I_reg_rdfall[R_status]),
    .inc_i      (vram_go),
    .inc_32_i   (ctrl_q[2]),
    .data_i     (I_data),
    .t_o        (O_t),
    .v_o        (v_cur),
    .fine_x_o   (O_fine_x)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_idle: begin
        if (data_wr) begin
          state_d = S_wr;
        end else if (data_rd) begin
          state_d = S_rd;
        end
      end
      S_rd, S_wr: begin
        if (I_vram_ack) begin
          state_d = S_idle;
        end
      end
      default: state_d = S_idle;
    endcase
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    mask_d       = mask_q;
    oam_addr_d   = oam_addr_q;
    oam_wren_d   = 1'b0;
    oam_wdata_d  = oam_wdata_q;
    open_bus_d   = open_bus_q;
    vblank_d     = vblank_q;
    buf_d        = buf_q;
    data_d       = data_q;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;

    if (|I_reg_wrfall) begin
      open_bus_d = I_data;
    end
    if (I_reg_wrfall[R_ctrl]) begin
      ctrl_d = I_data;
    end
    if (I_reg_wrfall[R_mask]) begin
      mask_d = I_data;
    end

    // The address advances the cycle after the OAM write pulse, so the pulse
    // itself is presented with the pre-increment address.
    if (oam_wren_q) begin
      oam_addr_d = oam_addr_q + 8'd1;
    end
    if (I_reg_wrfall[R_oamaddr]) begin
      oam_addr_d = I_data;
    end
    if (I_reg_wrfall[R_oamdata]) begin
      oam_wren_d  = 1'b1;
      oam_wdata_d = I_data;
    end

    if (vram_go) begin
      vram_addr_d = v_cur[13:0];
    end
    if (data_wr && idle) begin
      vram_wdata_d = I_data;
    end
    if ((state_q == S_rd) && I_vram_ack) begin
      buf_d = I_vram_rdata;
    end

    if (|I_reg_rdrise) begin
      if (I_reg_rdrise[R_status]) begin
        data_d = status_byte(vblank_q, I_spr0_hit, I_spr_ovf, open_bus_q);
      end else if (I_reg_rdrise[R_oamdata]) begin
        data_d = I_oam_rdata;
      end else if (I_reg_rdrise[R_data]) begin
        data_d = buf_q;
      end else begin
        data_d = open_bus_q;
      end
    end

    // A set landing on the status read start is swallowed so the read and the
    // flag agree; the pre-render clear beats everything.
    if (I_vblank_set && !I_reg_rdrise[R_status]) begin
      vblank_d = 1'b1;
    end
    if (I_reg_rdfall[R_status]) begin
      vblank_d = 1'b0;
    end
    if (I_vblank_clear) begin
      vblank_d = 1'b0;
    end
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_q      <= S_idle;
      ctrl_q       <= '0;
      mask_q       <= '0;
      oam_addr_q   <= '0;
      oam_wren_q   <= 1'b0;
      oam_wdata_q  <= '0;
      open_bus_q   <= '0;
      vblank_q     <= 1'b0;
      buf_q        <= '0;
      data_q       <= '0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      mask_q       <= mask_d;
      oam_addr_q   <= oam_addr_d;
      oam_wren_q   <= oam_wren_d;
      oam_wdata_q  <= oam_wdata_d;
      open_bus_q   <= open_bus_d;
      vblank_q     <= vblank_d;
      buf_q        <= buf_d;
      data_q       <= data_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
    end
  end

  assign O_data       = data_q;
  assign O_ctrl       = ctrl_q;
  assign O_mask       = mask_q;
  assign O_oam_addr   = oam_addr_q;
  assign O_oam_wren   = oam_wren_q;
  assign O_oam_wdata  = oam_wdata_q;
  assign O_v          = v_cur;
  assign O_vram_req   = (state_q != S_idle);
  assign O_vram_we    = (state_q == S_wr);
  assign O_vram_addr  = vram_addr_q;
  assign O_vram_wdata = vram_wdata_q;
  assign O_nmi        = vblank_q & ctrl_q[7];

endmodule

// File: tb/tb_video_regfile.sv
// Bench for video_regfile: scenario tasks with a VRAM responder model and
// queues of expected read data / VRAM transactions.
module tb_video_regfile;

  logic        I_clock = 1'b0;
  logic        I_reset;
  logic [7:0]  I_reg_wrfall, I_reg_rdrise, I_reg_rdfall, I_data;
  logic [7:0]  O_data;
  logic        I_vblank_set, I_vblank_clear, I_spr0_hit, I_spr_ovf;
  logic [7:0]  O_ctrl, O_mask, O_oam_addr, O_oam_wdata, I_oam_rdata;
  logic        O_oam_wren;
  logic [14:0] O_v, O_t;
  logic [2:0]  O_fine_x;
  logic        O_vram_req, O_vram_we, I_vram_ack, O_nmi;
  logic [13:0] O_vram_addr;
  logic [7:0]  O_vram_wdata, I_vram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  rd_exp_q[$];
  logic [22:0] txn_exp_q[$];
  logic [22:0] txn_obs_q[$];
  logic [7:0]  mem [0:16383];

  logic        auto_ack = 1'b1;
  logic        manual_ack = 1'b0;
  logic [7:0]  manual_rdata = 8'h00;
  int          lat = 0;
  int          lat_cnt = 0;

  video_regfile #(.P_inc_wrap(15)) dut (
    .I_clock(I_clock), .I_reset(I_reset),
    .I_reg_wrfall(I_reg_wrfall), .I_reg_rdrise(I_reg_rdrise), .I_reg_rdfall(I_reg_rdfall),
    .I_data(I_data), .O_data(O_data),
    .I_vblank_set(I_vblank_set), .I_vblank_clear(I_vblank_clear),
    .I_spr0_hit(I_spr0_hit), .I_spr_ovf(I_spr_ovf),
    .O_ctrl(O_ctrl), .O_mask(O_mask), .O_oam_addr(O_oam_addr),
    .O_oam_wren(O_oam_wren), .O_oam_wdata(O_oam_wdata), .I_oam_rdata(I_oam_rdata),
    .O_v(O_v), .O_t(O_t), .O_fine_x(O_fine_x),
    .O_vram_req(O_vram_req), .O_vram_we(O_vram_we), .O_vram_addr(O_vram_addr),
    .O_vram_wdata(O_vram_wdata), .I_vram_ack(I_vram_ack), .I_vram_rdata(I_vram_rdata),
    .O_nmi(O_nmi)
  );

  always #5 I_clock = ~I_clock;

  // VRAM responder: acks after lat request cycles and logs each transaction.
  initial begin
    I_vram_ack = 1'b0;
    I_vram_rdata = 8'h00;
    forever begin
      @(posedge I_clock);
      #2;
      if (!auto_ack) begin
        I_vram_ack = manual_ack;
        I_vram_rdata = manual_rdata;
      end else begin
        I_vram_ack = 1'b0;
        if (O_vram_req) begin
          if (lat_cnt >= lat) begin
            I_vram_ack = 1'b1;
            lat_cnt = 0;
            txn_obs_q.push_back({O_vram_we, O_vram_addr, O_vram_wdata});
            if (O_vram_we) mem[O_vram_addr] = O_vram_wdata;
            else I_vram_rdata = mem[O_vram_addr];
          end else begin
            lat_cnt++;
          end
        end else begin
          lat_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge I_clock);
    #1;
  endtask

  task automatic wr(input int idx, input logic [7:0] d);
    I_data = d;
    I_reg_wrfall = 8'(1 << idx);
    tick();
    I_reg_wrfall = 8'h00;
  endtask

  task automatic rd(input int idx, output logic [7:0] d);
    I_reg_rdrise = 8'(1 << idx);
    tick();
    I_reg_rdrise = 8'h00;
    d = O_data;
    I_reg_rdfall = 8'(1 << idx);
    tick();
    I_reg_rdfall = 8'h00;
  endtask

  task automatic wait_txn();
    for (int i = 0; i < 40 && txn_obs_q.size() == 0; i++) tick();
  endtask

  task automatic test_reset();
    I_reset = 1'b1;
    tick(); tick();
    I_reset = 1'b0;
    n_checks++;
    if ({O_data, O_ctrl, O_mask, O_oam_addr, O_oam_wren, O_vram_req, O_nmi} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_regs got=%h exp=0", {O_data, O_ctrl, O_mask, O_oam_addr, O_oam_wren, O_vram_req, O_nmi});
    end
    n_checks++;
    if ({O_v, O_t, O_fine_x} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_scroll got v=%h t=%h fx=%0d exp=0", O_v, O_t, O_fine_x);
    end
  endtask

  task automatic test_addr_latch();
    logic [7:0] got, exp;
    wr(6, 8'h21);
    wr(6, 8'h08);
    n_checks++;
    if (O_t !== 15'h2108 || O_v !== 15'h2108) begin
      n_fail++;
      $display("FAIL addr_2108 got t=%h v=%h exp 2108", O_t, O_v);
    end
    wr(6, 8'h15);
    rd_exp_q.push_back(8'h15);
    rd(2, got);
    exp = rd_exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL status_openbus got=%h exp=%h", got, exp);
    end
    wr(6, 8'h23);
    n_checks++;
    if (O_t !== 15'h2308 || O_v !== 15'h2108) begin
      n_fail++;
      $display("FAIL w_reset_by_status got t=%h v=%h exp t=2308 v=2108", O_t, O_v);
    end
    wr(6, 8'h44);
    n_checks++;
    if (O_t !== 15'h2344 || O_v !== 15'h2344) begin
      n_fail++;
      $display("FAIL addr_2344 got t=%h v=%h exp 2344", O_t, O_v);
    end
  endtask

  task automatic test_scroll();
    wr(5, 8'h7D);
    wr(5, 8'h5E);
    n_checks++;
    if (O_fine_x !== 3'd5 || O_t[4:0] !== 5'h0F || O_t[9:5] !== 5'h0B || O_t[14:12] !== 3'd6) begin
      n_fail++;
      $display("FAIL scroll got fx=%0d t=%h exp fx=5 t[4:0]=0F t[9:5]=0B t[14:12]=6", O_fine_x, O_t);
    end
  endtask

  task automatic test_vram_write();
    logic [22:0] o, e;
    wr(0, 8'h04);
    wr(6, 8'h3F);
    wr(5, 8'hFF);
    wr(5, 8'h00);
    wr(6, 8'hF0);
    n_checks++;
    if (O_v !== 15'h7FF0) begin
      n_fail++;
      $display("FAIL v_setup got=%h exp=7ff0", O_v);
    end
    lat = 2;
    txn_exp_q.push_back({1'b1, 14'h3FF0, 8'hAA});
    wr(7, 8'hAA);
    n_checks++;
    if ({O_vram_req, O_vram_we, O_vram_addr, O_vram_wdata} !== {2'b11, 14'h3FF0, 8'hAA}) begin
      n_fail++;
      $display("FAIL wr_req got req=%b we=%b addr=%h wd=%h exp 1 1 3ff0 aa",
               O_vram_req, O_vram_we, O_vram_addr, O_vram_wdata);
    end
    n_checks++;
    if (O_v !== 15'h0010) begin
      n_fail++;
      $display("FAIL v_wrap32 got=%h exp=0010", O_v);
    end
    wait_txn();
    n_checks++;
    if (txn_obs_q.size() == 0) begin
      n_fail++;
      $display("FAIL wr_ack_timeout got=none exp=transaction");
    end else begin
      o = txn_obs_q.pop_front();
      e = txn_exp_q.pop_front();
      if (o !== e) begin
        n_fail++;
        $display("FAIL wr_txn got=%h exp=%h", o, e);
      end
    end
    tick();
    n_checks++;
    if (O_vram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_req_drop got=%b exp=0", O_vram_req);
    end
  endtask

  task automatic test_vram_read();
    logic [7:0]  got, exp;
    logic [22:0] o, e;
    lat = 0;
    wr(0, 8'h00);
    mem[14'h2000] = 8'h11;
    mem[14'h2001] = 8'h22;
    mem[14'h2002] = 8'h33;
    wr(6, 8'h20);
    wr(6, 8'h00);
    for (int i = 0; i < 3; i++) begin
      rd_exp_q.push_back(i == 0 ? 8'h00 : (i == 1 ? 8'h11 : 8'h22));
      txn_exp_q.push_back({1'b0, 14'(14'h2000 + i), 8'h00});
      rd(7, got);
      exp = rd_exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ppudata_read%0d got=%h exp=%h", i, got, exp);
      end
      wait_txn();
      n_checks++;
      if (txn_obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_ack_timeout%0d got=none exp=transaction", i);
      end else begin
        o = txn_obs_q.pop_front();
        e = txn_exp_q.pop_front();
        if (o[22:8] !== e[22:8]) begin
          n_fail++;
          $display("FAIL rd_txn%0d got=%h exp=%h", i, o[22:8], e[22:8]);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (O_v !== 15'h2002) begin
          n_fail++;
          $display("FAIL v_after_reads got=%h exp=2002", O_v);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] o, e;
    lat = 3;
    txn_exp_q.push_back({1'b1, 14'h2003, 8'h55});
    wr(7, 8'h55);
    wr(7, 8'h66);
    n_checks++;
    if (O_v !== 15'h2004) begin
      n_fail++;
      $display("FAIL busy_drop_v got=%h exp=2004", O_v);
    end
    wait_txn();
    n_checks++;
    if (txn_obs_q.size() == 0) begin
      n_fail++;
      $display("FAIL b2b_ack_timeout got=none exp=transaction");
    end else begin
      o = txn_obs_q.pop_front();
      e = txn_exp_q.pop_front();
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b_txn got=%h exp=%h", o, e);
      end
    end
    lat = 0;
    txn_exp_q.push_back({1'b1, 14'h2004, 8'h77});
    wr(7, 8'h77);
    n_checks++;
    if (O_v !== 15'h2005 || O_vram_req !== 1'b1) begin
      n_fail++;
      $display("FAIL next_after_ack got v=%h req=%b exp v=2005 req=1", O_v, O_vram_req);
    end
    wait_txn();
    tick(); tick();
    n_checks++;
    if (txn_obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL b2b_txn_count got=%0d exp=1", txn_obs_q.size());
    end else begin
      o = txn_obs_q.pop_front();
      e = txn_exp_q.pop_front();
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b_txn2 got=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_oam();
    logic [7:0] got, exp;
    wr(3, 8'hFE);
    wr(4, 8'h12);
    n_checks++;
    if ({O_oam_wren, O_oam_wdata, O_oam_addr} !== {1'b1, 8'h12, 8'hFE}) begin
      n_fail++;
      $display("FAIL oam_pulse got wren=%b wd=%h addr=%h exp 1 12 fe", O_oam_wren, O_oam_wdata, O_oam_addr);
    end
    tick();
    n_checks++;
    if (O_oam_wren !== 1'b0 || O_oam_addr !== 8'hFF) begin
      n_fail++;
      $display("FAIL oam_inc got wren=%b addr=%h exp 0 ff", O_oam_wren, O_oam_addr);
    end
    wr(4, 8'h34);
    tick();
    n_checks++;
    if (O_oam_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL oam_wrap got=%h exp=00", O_oam_addr);
    end
    I_oam_rdata = 8'h9C;
    rd_exp_q.push_back(8'h9C);
    rd(4, got);
    exp = rd_exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL oam_read got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_vblank_nmi();
    logic [7:0] got, exp;
    wr(0, 8'h80);
    I_spr0_hit = 1'b1;
    I_vblank_set = 1'b1;
    tick();
    I_vblank_set = 1'b0;
    n_checks++;
    if (O_nmi !== 1'b1) begin
      n_fail++;
      $display("FAIL nmi_on got=%b exp=1", O_nmi);
    end
    rd_exp_q.push_back(8'hC0);
    rd(2, got);
    exp = rd_exp_q.pop_front();
    n_checks++;
    if (got !== exp || O_nmi !== 1'b0) begin
      n_fail++;
      $display("FAIL status_vbl got=%h nmi=%b exp=%h nmi=0", got, O_nmi, exp);
    end
    I_reg_rdrise = 8'h04;
    I_vblank_set = 1'b1;
    tick();
    I_reg_rdrise = 8'h00;
    I_vblank_set = 1'b0;
    n_checks++;
    if (O_data !== 8'h40 || O_nmi !== 1'b0) begin
      n_fail++;
      $display("FAIL vbl_suppress got data=%h nmi=%b exp 40 0", O_data, O_nmi);
    end
    I_reg_rdfall = 8'h04;
    tick();
    I_reg_rdfall = 8'h00;
    I_vblank_set = 1'b1;
    I_vblank_clear = 1'b1;
    tick();
    I_vblank_set = 1'b0;
    I_vblank_clear = 1'b0;
    n_checks++;
    if (O_nmi !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_wins got=%b exp=0", O_nmi);
    end
    I_vblank_set = 1'b1;
    tick();
    I_vblank_set = 1'b0;
    I_vblank_clear = 1'b1;
    tick();
    I_vblank_clear = 1'b0;
    n_checks++;
    if (O_nmi !== 1'b0) begin
      n_fail++;
      $display("FAIL prerender_clear got=%b exp=0", O_nmi);
    end
    I_spr0_hit = 1'b0;
    rd_exp_q.push_back(8'h80);
    rd(0, got);
    exp = rd_exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL open_bus_read got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, exp;
    auto_ack = 1'b0;
    manual_ack = 1'b0;
    rd(7, got);
    n_checks++;
    if (O_vram_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_req_up got=%b exp=1", O_vram_req);
    end
    I_reset = 1'b1;
    tick();
    n_checks++;
    if ({O_vram_req, O_vram_we, O_data, O_ctrl, O_mask, O_oam_addr, O_oam_wren, O_nmi,
         O_v, O_t, O_fine_x, O_vram_addr, O_vram_wdata} !== 90'd0) begin
      n_fail++;
      $display("FAIL reset_mid got req=%b data=%h ctrl=%h v=%h t=%h exp all 0",
               O_vram_req, O_data, O_ctrl, O_v, O_t);
    end
    I_reset = 1'b0;
    manual_rdata = 8'hEE;
    manual_ack = 1'b1;
    tick();
    manual_ack = 1'b0;
    tick();
    rd_exp_q.push_back(8'h00);
    rd(7, got);
    exp = rd_exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL late_ack_buffer got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    I_reset = 1'b1;
    I_reg_wrfall = 8'h00;
    I_reg_rdrise = 8'h00;
    I_reg_rdfall = 8'h00;
    I_data = 8'h00;
    I_vblank_set = 1'b0;
    I_vblank_clear = 1'b0;
    I_spr0_hit = 1'b0;
    I_spr_ovf = 1'b0;
    I_oam_rdata = 8'h00;
    test_reset();
    test_addr_latch();
    test_scroll();
    test_vram_write();
    test_vram_read();
    test_back_to_back();
    test_oam();
    test_vblank_nmi();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
